// File: rtl/t_modcnt_if.sv
// Control and status bundle for the t_modcnt modulo toggle counter.
// The master side drives control and load data; the slave side (the counter)
// returns the count, the toggle mask for the T flip-flop bank and status.
interface t_modcnt_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] mod_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_vec;
    logic             tc;
    logic             busy;

    modport master (
        output start, stop, en, up, load, din, mod_val,
        input  q, t_vec, tc, busy
    );

    modport slave (
        input  start, stop, en, up, load, din, mod_val,
        output q, t_vec, tc, busy
    );
endinterface

// File: rtl/t_modcnt.sv
// Programmable modulo up/down counter expressed as a toggle mask.
// Every edge computes the next count, registers it as q and registers the
// per-bit toggle pattern t_vec = q_old ^ q_new that the downstream T-flop bank
// consumes. A two-state IDLE/RUN FSM gates stepping; load works in any state.
module t_modcnt #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    t_modcnt_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             busy_c;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] t_r;
    logic             tc_r;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;

    // Top of the count range; mod_val = 0 wraps to all-ones, i.e. modulus 2^WIDTH.
    assign top = bus.mod_val - 1'b1;

    // State register: synchronous reset to IDLE.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: stop wins over start while running; start needs stop low in IDLE.
    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && !bus.stop) state_nxt = RUN;
            RUN:     if (bus.stop)               state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy reflects the registered state only.
    always_comb begin
        busy_c = (state == RUN);
    end

    // Ripple toggle masks: up toggles bit i when all lower bits are 1, down when all are 0.
    always_comb begin
        logic ones_run;
        logic zeros_run;
        ones_run  = 1'b1;
        zeros_run = 1'b1;
        t_up      = '0;
        t_dn      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i]   = ones_run;
            t_dn[i]   = zeros_run;
            ones_run  = ones_run & q_r[i];
            zeros_run = zeros_run & ~q_r[i];
        end
    end

    // Next count and terminal-count: load > step > hold.
    always_comb begin
        q_nxt  = q_r;
        tc_nxt = 1'b0;
        if (bus.load) begin
            q_nxt = (bus.din > top) ? top : bus.din;
        end else if (state == RUN && bus.en) begin
            if (bus.up) begin
                if (q_r >= top) begin
                    q_nxt  = '0;
                    tc_nxt = 1'b1;
                end else begin
                    q_nxt = q_r ^ t_up;
                end
            end else begin
                if (q_r == '0) begin
                    q_nxt  = top;
                    tc_nxt = 1'b1;
                end else if (q_r > top) begin
                    // Modulus shrank under a high count: clamp without a wrap pulse.
                    q_nxt = top;
                end else begin
                    q_nxt = q_r ^ t_dn;
                end
            end
        end
    end

    // Output registers: count, applied toggle mask and one-cycle terminal-count pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r  <= '0;
            t_r  <= '0;
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_nxt;
            t_r  <= q_r ^ q_nxt;
            tc_r <= tc_nxt;
        end
    end

    assign bus.q     = q_r;
    assign bus.t_vec = t_r;
    assign bus.tc    = tc_r;
    assign bus.busy  = busy_c;
endmodule
